skip_addsub_pipe: RTL and testbench

- Parametrised, pipelined carry-skip adder/subtractor.
- Generalises the fixed 32-bit, 4-bit-block carry-skip adder to any width, block size and pipeline depth.
- Adds subtract mode, signed-overflow and zero flags, and a valid/ready handshake with backpressure.
- Sits in the datapath as the shared add/sub unit feeding downstream ALU result registers.

---
 rtl/skip_addsub_pipe.sv | 160 ++++++++++++++++
 tb/tb_skip_addsub_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skip_addsub_pipe.sv
// Pipelined carry-skip adder/subtractor with valid/ready handshake.
// Each of STAGES register stages resolves WIDTH/STAGES bits using BLOCK-bit
// ripple groups with a skip mux. The remaining upper operand bits and the
// operand sign bits travel alongside the partial sum. A single global stall
// freezes every stage while the output is held by the consumer.
module skip_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    // Bits resolved per stage
    localparam int SW = WIDTH / STAGES;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             stall;

    // Carry-skip add of one stage slice; returns {carry_out, sum}
    function automatic logic [SW:0] skip_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                             input logic cin);
        logic [SW-1:0] sum;
        logic          c;
        logic          rc;
        logic          p;
        sum = '0;
        c   = cin;
        for (int g = 0; g < SW / BLOCK; g++) begin
            rc = c;
            p  = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                sum[g*BLOCK+i] = x[g*BLOCK+i] ^ y[g*BLOCK+i] ^ rc;
                rc = (x[g*BLOCK+i] & y[g*BLOCK+i]) | (rc & (x[g*BLOCK+i] ^ y[g*BLOCK+i]));
                p  = p & (x[g*BLOCK+i] ^ y[g*BLOCK+i]);
            end
            // All bits propagate: the group carry-in skips straight through
            c = p ? c : rc;
        end
        return {c, sum};
    endfunction

    // Subtract is A + ~B + ~ci, so borrow-in maps to an inverted carry-in
    always_comb begin
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? ~ci : ci;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int Rem = WIDTH - k * SW;  // operand bits still unresolved
        localparam int Lo  = (k + 1) * SW;    // sum bits known after this stage

        logic [Rem-1:0] a_in;
        logic [Rem-1:0] b_in;
        logic           c_in;
        logic           v_in;
        logic           sa_in;
        logic           sb_in;
        logic [SW:0]    r;
        logic [Lo-1:0]  s_nx;
        logic [Lo-1:0]  s_q;
        logic           c_q;
        logic           v_q;

        assign r = skip_add(a_in[SW-1:0], b_in[SW-1:0], c_in);

        if (k == 0) begin : g_head
            assign a_in  = a;
            assign b_in  = b_eff;
            assign c_in  = cin_eff;
            assign v_in  = in_valid;
            assign sa_in = a[WIDTH-1];
            assign sb_in = b_eff[WIDTH-1];
            assign s_nx  = r[SW-1:0];
        end else begin : g_chain
            assign a_in  = g_st[k-1].g_fwd.a_q;
            assign b_in  = g_st[k-1].g_fwd.b_q;
            assign c_in  = g_st[k-1].c_q;
            assign v_in  = g_st[k-1].v_q;
            assign sa_in = g_st[k-1].g_fwd.sa_q;
            assign sb_in = g_st[k-1].g_fwd.sb_q;
            assign s_nx  = {r[SW-1:0], g_st[k-1].s_q};
        end

        // Stage result register: partial sum, carry and valid
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (!stall) begin
                s_q <= s_nx;
                c_q <= r[SW];
                v_q <= v_in;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [Rem-SW-1:0] a_q;
            logic [Rem-SW-1:0] b_q;
            logic              sa_q;
            logic              sb_q;

            // Forward unresolved operand bits and sign bits to the next stage
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    sa_q <= 1'b0;
                    sb_q <= 1'b0;
                end else if (!stall) begin
                    a_q  <= a_in[Rem-1:SW];
                    b_q  <= b_in[Rem-1:SW];
                    sa_q <= sa_in;
                    sb_q <= sb_in;
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic zero_q;

            // Flags from the completed sum, registered alongside it
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q  <= (sa_in == sb_in) && (s_nx[WIDTH-1] != sa_in);
                    zero_q <= ~|s_nx;
                end
            end
        end
    end

    // Global stall: the whole pipe freezes while the output is refused
    always_comb begin
        out_valid = g_st[STAGES-1].v_q;
        stall     = out_valid && !out_ready;
        in_ready  = !stall;
        s         = g_st[STAGES-1].s_q;
        co        = g_st[STAGES-1].c_q;
        ovf       = g_st[STAGES-1].g_last.ovf_q;
        zero      = g_st[STAGES-1].g_last.zero_q;
    end

endmodule

// File: tb/tb_skip_addsub_pipe.sv
// Bench for skip_addsub_pipe: directed vectors, backpressure and mid-op reset
// on the default 32/4/2 build, plus randomized handshake traffic on 16/4/4 and
// 64/8/1 builds checked against an arithmetic reference model.
module tb_skip_addsub_pipe;

    logic clk;
    int   n_tests;
    int   n_fail;
    int   rnd_done;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide addition of a, conditioned b and carry-in, flags from the result
    function automatic logic [127:0] model(input int w, input logic [63:0] av,
                                           input logic [63:0] bv, input logic civ,
                                           input logic subv);
        logic [63:0] m;
        logic [63:0] be;
        logic [64:0] full;
        logic [63:0] sv;
        logic        cov;
        logic        ov;
        logic        zv;
        m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        be   = (subv ? ~bv : bv) & m;
        full = {1'b0, av & m} + {1'b0, be} + {64'd0, (subv ? ~civ : civ)};
        sv   = full[63:0] & m;
        cov  = full[w];
        ov   = (av[w-1] == be[w-1]) && (sv[w-1] != av[w-1]);
        zv   = (sv == 64'd0);
        return {61'd0, zv, ov, cov, sv};
    endfunction

    // Directed DUT: default parameters
    logic        d_rst_n;
    logic        d_iv;
    logic        d_ir;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic        d_ci;
    logic        d_sub;
    logic        d_ov;
    logic        d_ordy;
    logic [31:0] d_s;
    logic        d_co;
    logic        d_ovf;
    logic        d_zero;

    skip_addsub_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u_dut (
        .clk       (clk),
        .rst_n     (d_rst_n),
        .in_valid  (d_iv),
        .in_ready  (d_ir),
        .a         (d_a),
        .b         (d_b),
        .ci        (d_ci),
        .sub       (d_sub),
        .out_valid (d_ov),
        .out_ready (d_ordy),
        .s         (d_s),
        .co        (d_co),
        .ovf       (d_ovf),
        .zero      (d_zero)
    );

    task automatic d_beat(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic civ, input logic subv, input logic [31:0] es,
                          input logic eco, input logic eovf, input logic ez);
        int lat;
        @(negedge clk);
        d_a    = av;
        d_b    = bv;
        d_ci   = civ;
        d_sub  = subv;
        d_iv   = 1'b1;
        d_ordy = 1'b1;
        @(negedge clk);
        d_iv = 1'b0;
        lat  = 1;
        while (!d_ov && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, 2);
        check({tag, "_s"}, d_s, es);
        check({tag, "_flags"}, {d_co, d_ovf, d_zero}, {eco, eovf, ez});
    endtask

    // Random sweep DUTs: 16/4/4 and 64/8/1
    for (genvar c = 0; c < 2; c++) begin : g_rnd
        localparam int W  = (c == 0) ? 16 : 64;
        localparam int BL = (c == 0) ? 4 : 8;
        localparam int ST = (c == 0) ? 4 : 1;

        logic         iv;
        logic         ir;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rci;
        logic         rsub;
        logic         ov;
        logic         ordy;
        logic [W-1:0] rs;
        logic         rco;
        logic         rovf;
        logic         rzero;

        skip_addsub_pipe #(.WIDTH(W), .BLOCK(BL), .STAGES(ST)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (ra),
            .b         (rb),
            .ci        (rci),
            .sub       (rsub),
            .out_valid (ov),
            .out_ready (ordy),
            .s         (rs),
            .co        (rco),
            .ovf       (rovf),
            .zero      (rzero)
        );

        initial begin
            logic [127:0] q[$];
            logic [127:0] e;
            logic [63:0]  t;
            logic [W-1:0] s_prev;
            logic         stalled_prev;
            logic         hold;
            int           acc;
            int           cyc;
            acc          = 0;
            cyc          = 0;
            hold         = 1'b0;
            stalled_prev = 1'b0;
            s_prev       = '0;
            iv           = 1'b0;
            ordy         = 1'b0;
            ra           = '0;
            rb           = '0;
            rci          = 1'b0;
            rsub         = 1'b0;
            @(posedge rst_n);
            @(negedge clk);
            while (acc < 10000 && cyc < 40000) begin
                if (!hold) begin
                    iv   = ($urandom_range(0, 3) != 0);
                    t    = {$urandom(), $urandom()};
                    ra   = t[W-1:0];
                    t    = {$urandom(), $urandom()};
                    rb   = t[W-1:0];
                    rci  = 1'($urandom_range(0, 1));
                    rsub = 1'($urandom_range(0, 1));
                end
                ordy = ($urandom_range(0, 3) != 0);
                #1;
                if (stalled_prev) begin
                    check($sformatf("rnd%0d_hold", W),
                          {ov, 64'(rs)}, {1'b1, 64'(s_prev)});
                end
                if (ov && ordy) begin
                    if (q.size() == 0) begin
                        check($sformatf("rnd%0d_spurious", W), 1, 0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("rnd%0d_res", W),
                              {61'd0, rzero, rovf, rco, 64'(rs)}, e);
                    end
                end
                if (iv && ir) begin
                    q.push_back(model(W, 64'(ra), 64'(rb), rci, rsub));
                    acc++;
                end
                hold         = iv && !ir;
                stalled_prev = ov && !ordy;
                s_prev       = rs;
                cyc++;
                @(negedge clk);
            end
            check($sformatf("rnd%0d_accepted", W), acc, 10000);
            iv   = 1'b0;
            ordy = 1'b1;
            cyc  = 0;
            while (q.size() > 0 && cyc < 50) begin
                #1;
                if (ov) begin
                    e = q.pop_front();
                    check($sformatf("rnd%0d_drain_res", W),
                          {61'd0, rzero, rovf, rco, 64'(rs)}, e);
                end
                cyc++;
                @(negedge clk);
            end
            check($sformatf("rnd%0d_drain", W), q.size(), 0);
            rnd_done++;
        end
    end

    initial begin
        logic [31:0] exp_r[4];
        int          idx;
        int          got;
        int          stale;
        n_tests  = 0;
        n_fail   = 0;
        rnd_done = 0;
        rst_n    = 1'b0;
        d_rst_n  = 1'b0;
        d_iv     = 1'b0;
        d_ordy   = 1'b0;
        d_a      = '0;
        d_b      = '0;
        d_ci     = 1'b0;
        d_sub    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", {d_ov, d_s, d_co, d_ovf, d_zero}, 36'd0);
        d_rst_n = 1'b1;
        rst_n   = 1'b1;
        @(negedge clk);
        check("rst_in_ready", d_ir, 1'b1);

        d_beat("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1, 0, 1);
        d_beat("skip_c1",  32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1, 0, 1);
        d_beat("skip_c0",  32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF, 0, 0, 0);
        d_beat("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1, 1, 0);
        d_beat("sub_brw",  32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 0, 0, 0);
        d_beat("sub_bin",  32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1, 0, 0);
        d_beat("add_povf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 0, 1, 0);

        // Backpressure: consumer refuses for 5 cycles
        exp_r[0] = 32'd2;
        exp_r[1] = 32'd4;
        exp_r[2] = 32'd6;
        exp_r[3] = 32'd8;
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            @(negedge clk);
            d_ordy = (cyc >= 5);
            d_iv   = (idx < 4);
            d_a    = 32'(idx + 1);
            d_b    = 32'(idx + 1);
            d_ci   = 1'b0;
            d_sub  = 1'b0;
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                check("bp_in_ready", d_ir, 1'b0);
                check("bp_hold_s", {d_ov, d_s}, {1'b1, 32'd2});
            end
            if (d_ov && d_ordy) begin
                if (got < 4) check($sformatf("bp_res%0d", got), d_s, exp_r[got]);
                got++;
            end
            if (d_iv && d_ir) idx++;
        end
        check("bp_count", got, 4);
        d_iv = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_no_dup", d_ov, 1'b0);

        // Reset while two beats are stalled in the pipe
        @(negedge clk);
        d_ordy = 1'b0;
        d_iv   = 1'b1;
        d_a    = 32'd10;
        d_b    = 32'd10;
        @(negedge clk);
        d_a = 32'd20;
        d_b = 32'd20;
        @(negedge clk);
        d_iv = 1'b0;
        check("rm_full", {d_ov, d_ir}, 2'b10);
        d_rst_n = 1'b0;
        @(negedge clk);
        check("rm_cleared", {d_ov, d_s, d_co, d_ovf, d_zero}, 36'd0);
        check("rm_in_ready", d_ir, 1'b1);
        d_rst_n = 1'b1;
        d_ordy  = 1'b1;
        stale   = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_ov) stale++;
        end
        check("rm_no_stale", stale, 0);

        for (int i = 0; i < 60000 && rnd_done < 2; i++) @(negedge clk);
        check("rnd_finished", rnd_done, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
